// File: rtl/xbar_slave_port.sv
// rtl/xbar_slave_port.sv - master-facing crossbar port: request buffering, address decode, W steering, R/B return arbitration
module xbar_slave_port_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

module xbar_slave_port_rr #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [0:N-1] cand,
    input  logic         sink_ready,
    input  logic         lock_next,
    output logic [W-1:0] gnt,
    output logic         accept
);
    logic [W-1:0] ptr;
    logic [W-1:0] lock_slave;
    logic [W-1:0] idx;
    logic         locked;
    logic         found;

    // Search begins one past the last granted slave; a held lock skips the search.
    always_comb begin
        gnt   = ptr;
        found = 1'b0;
        idx   = '0;
        if (locked) begin
            gnt   = lock_slave;
            found = cand[lock_slave];
        end else begin
            for (int i = 1; i <= N; i++) begin
                idx = ptr + W'(i);
                if (!found && cand[idx]) begin
                    gnt   = idx;
                    found = 1'b1;
                end
            end
        end
        accept = found & sink_ready;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr        <= '0;
            lock_slave <= '0;
            locked     <= 1'b0;
        end else if (accept) begin
            ptr        <= gnt;
            lock_slave <= gnt;
            locked     <= lock_next;
        end
    end
endmodule

module xbar_slave_port #(
    parameter int ID_WIDTH           = 4,
    parameter int ADDR_WIDTH         = 32,
    parameter int LEN_WIDTH          = 4,
    parameter int SIZE_WIDTH         = 3,
    parameter int DATA_WIDTH         = 32,
    parameter int STRB_WIDTH         = 4,
    parameter int pending_depth      = 8,
    parameter int masters            = 2,
    parameter int slaves             = 2,
    parameter int i_am_master_number = 0,
    localparam int SW = (slaves > 1) ? $clog2(slaves) : 1,
    localparam int MW = (masters > 1) ? $clog2(masters) : 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ID_WIDTH-1:0]   ARID,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [LEN_WIDTH-1:0]  ARLEN,
    input  logic [SIZE_WIDTH-1:0] ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [ID_WIDTH-1:0]   AWID,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [LEN_WIDTH-1:0]  AWLEN,
    input  logic [SIZE_WIDTH-1:0] AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [STRB_WIDTH-1:0] WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [ID_WIDTH-1:0]   RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [ID_WIDTH-1:0]   BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [ID_WIDTH-1:0]   ARID_F,
    output logic [ADDR_WIDTH-1:0] ARADDR_F,
    output logic [LEN_WIDTH-1:0]  ARLEN_F,
    output logic [SIZE_WIDTH-1:0] ARSIZE_F,
    output logic [1:0]            ARBURST_F,
    output logic [ID_WIDTH-1:0]   AWID_F,
    output logic [ADDR_WIDTH-1:0] AWADDR_F,
    output logic [LEN_WIDTH-1:0]  AWLEN_F,
    output logic [SIZE_WIDTH-1:0] AWSIZE_F,
    output logic [1:0]            AWBURST_F,
    output logic [DATA_WIDTH-1:0] WDATA_F,
    output logic [STRB_WIDTH-1:0] WSTRB_F,
    output logic                  WLAST_F,
    output logic                  master_read_addr_fifo_empty,
    output logic [SW-1:0]         read_addr_forward_dest_slave,
    input  logic [0:slaves-1]     slave_read_addr_fifo_full,
    input  logic [MW-1:0]         grant_read_addr_forward_master [0:slaves-1],
    output logic                  master_write_addr_fifo_empty,
    output logic [SW-1:0]         write_addr_forward_dest_slave,
    input  logic [0:slaves-1]     slave_write_addr_fifo_full,
    input  logic [MW-1:0]         grant_write_addr_forward_master [0:slaves-1],
    output logic [0:slaves-1]     master_write_data_fifo_empty,
    input  logic [0:slaves-1]     slave_write_data_fifo_full,
    input  logic [MW-1:0]         write_data_forward_src_master [0:slaves-1],
    input  logic [ID_WIDTH-1:0]   RID_F [0:slaves-1],
    input  logic [DATA_WIDTH-1:0] RDATA_F [0:slaves-1],
    input  logic [1:0]            RRESP_F [0:slaves-1],
    input  logic [0:slaves-1]     RLAST_F,
    input  logic [0:slaves-1]     slave_read_data_fifo_empty,
    input  logic [MW-1:0]         read_data_return_dest_master [0:slaves-1],
    output logic [0:slaves-1]     master_read_data_fifo_full,
    input  logic [ID_WIDTH-1:0]   BID_F [0:slaves-1],
    input  logic [1:0]            BRESP_F [0:slaves-1],
    input  logic [0:slaves-1]     slave_write_resp_fifo_empty,
    input  logic [MW-1:0]         write_resp_return_dest_master [0:slaves-1],
    output logic [0:slaves-1]     master_write_resp_fifo_full
);
    localparam logic [MW-1:0] ME = MW'(i_am_master_number);
    localparam int AXW = SW + ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH + 2;
    localparam int WW  = DATA_WIDTH + STRB_WIDTH + 1;
    localparam int RW  = ID_WIDTH + DATA_WIDTH + 3;
    localparam int BW  = ID_WIDTH + 2;

    logic [AXW-1:0] ar_head, aw_head;
    logic [WW-1:0]  w_head;
    logic [RW-1:0]  r_head;
    logic [BW-1:0]  b_head;
    logic [SW-1:0]  ar_dest, aw_dest, dq_head;
    logic           ar_empty, ar_full, ar_pop;
    logic           aw_empty, aw_full, aw_pop;
    logic           w_empty, w_full, w_pop;
    logic           dq_empty, dq_full;
    logic           r_empty, r_full, r_accept;
    logic           b_empty, b_full, b_accept;
    logic [SW-1:0]  r_gnt, b_gnt;
    logic [0:slaves-1] w_avail, r_cand, b_cand;

    assign ARREADY = ~ar_full;
    assign AWREADY = ~(aw_full | dq_full);
    assign WREADY  = ~w_full;

    xbar_slave_port_fifo #(.WIDTH(AXW), .DEPTH(pending_depth)) u_ar_fifo (
        .clk(ACLK), .resetn(ARESETn), .push(ARVALID & ARREADY),
        .push_data({ARADDR[ADDR_WIDTH-1 -: SW], ARID, ARADDR, ARLEN, ARSIZE, ARBURST}),
        .pop(ar_pop), .pop_data(ar_head), .empty(ar_empty), .full(ar_full)
    );
    assign {ar_dest, ARID_F, ARADDR_F, ARLEN_F, ARSIZE_F, ARBURST_F} = ar_head;
    assign master_read_addr_fifo_empty  = ar_empty;
    assign read_addr_forward_dest_slave = ar_empty ? '0 : ar_dest;
    assign ar_pop = ~ar_empty & (grant_read_addr_forward_master[ar_dest] == ME)
                  & ~slave_read_addr_fifo_full[ar_dest];

    xbar_slave_port_fifo #(.WIDTH(AXW), .DEPTH(pending_depth)) u_aw_fifo (
        .clk(ACLK), .resetn(ARESETn), .push(AWVALID & AWREADY),
        .push_data({AWADDR[ADDR_WIDTH-1 -: SW], AWID, AWADDR, AWLEN, AWSIZE, AWBURST}),
        .pop(aw_pop), .pop_data(aw_head), .empty(aw_empty), .full(aw_full)
    );
    assign {aw_dest, AWID_F, AWADDR_F, AWLEN_F, AWSIZE_F, AWBURST_F} = aw_head;
    // A forwarded AW must always find room for its destination, so hide the head while the queue is full.
    assign master_write_addr_fifo_empty  = aw_empty | dq_full;
    assign write_addr_forward_dest_slave = aw_empty ? '0 : aw_dest;
    assign aw_pop = ~aw_empty & ~dq_full & (grant_write_addr_forward_master[aw_dest] == ME)
                  & ~slave_write_addr_fifo_full[aw_dest];

    xbar_slave_port_fifo #(.WIDTH(SW), .DEPTH(pending_depth)) u_dest_queue (
        .clk(ACLK), .resetn(ARESETn), .push(aw_pop), .push_data(aw_dest),
        .pop(w_pop & WLAST_F), .pop_data(dq_head), .empty(dq_empty), .full(dq_full)
    );

    xbar_slave_port_fifo #(.WIDTH(WW), .DEPTH(pending_depth)) u_w_fifo (
        .clk(ACLK), .resetn(ARESETn), .push(WVALID & WREADY),
        .push_data({WDATA, WSTRB, WLAST}),
        .pop(w_pop), .pop_data(w_head), .empty(w_empty), .full(w_full)
    );
    assign {WDATA_F, WSTRB_F, WLAST_F} = w_head;

    // W beats follow the oldest forwarded AW that has not yet seen its WLAST.
    always_comb begin
        w_avail = '0;
        for (int s = 0; s < slaves; s++) begin
            w_avail[s] = ~w_empty & ~dq_empty & (dq_head == SW'(s))
                       & (write_data_forward_src_master[s] == ME) & ~slave_write_data_fifo_full[s];
        end
    end
    assign master_write_data_fifo_empty = ~w_avail;
    assign w_pop = |w_avail;

    always_comb begin
        r_cand = '0;
        b_cand = '0;
        master_read_data_fifo_full  = '1;
        master_write_resp_fifo_full = '1;
        for (int s = 0; s < slaves; s++) begin
            r_cand[s] = ~slave_read_data_fifo_empty[s] & (read_data_return_dest_master[s] == ME);
            b_cand[s] = ~slave_write_resp_fifo_empty[s] & (write_resp_return_dest_master[s] == ME);
            master_read_data_fifo_full[s]  = ~(r_accept & (r_gnt == SW'(s)));
            master_write_resp_fifo_full[s] = ~(b_accept & (b_gnt == SW'(s)));
        end
    end

    xbar_slave_port_rr #(.N(slaves), .W(SW)) u_r_arb (
        .clk(ACLK), .resetn(ARESETn), .cand(r_cand), .sink_ready(~r_full),
        .lock_next(~RLAST_F[r_gnt]), .gnt(r_gnt), .accept(r_accept)
    );

    xbar_slave_port_fifo #(.WIDTH(RW), .DEPTH(pending_depth)) u_r_fifo (
        .clk(ACLK), .resetn(ARESETn), .push(r_accept),
        .push_data({RID_F[r_gnt], RDATA_F[r_gnt], RRESP_F[r_gnt], RLAST_F[r_gnt]}),
        .pop(RREADY), .pop_data(r_head), .empty(r_empty), .full(r_full)
    );
    assign {RID, RDATA, RRESP, RLAST} = r_head;
    assign RVALID = ~r_empty;

    xbar_slave_port_rr #(.N(slaves), .W(SW)) u_b_arb (
        .clk(ACLK), .resetn(ARESETn), .cand(b_cand), .sink_ready(~b_full),
        .lock_next(1'b0), .gnt(b_gnt), .accept(b_accept)
    );

    xbar_slave_port_fifo #(.WIDTH(BW), .DEPTH(pending_depth)) u_b_fifo (
        .clk(ACLK), .resetn(ARESETn), .push(b_accept),
        .push_data({BID_F[b_gnt], BRESP_F[b_gnt]}),
        .pop(BREADY), .pop_data(b_head), .empty(b_empty), .full(b_full)
    );
    assign {BID, BRESP} = b_head;
    assign BVALID = ~b_empty;
endmodule

// File: tb/tb_xbar_slave_port.sv
// tb/tb_xbar_slave_port.sv - directed self-checking bench for xbar_slave_port
module tb_xbar_slave_port;
    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    logic [3:0] ARID, AWID, RID, BID, ARID_F, AWID_F;
    logic [31:0] ARADDR, AWADDR, WDATA, RDATA, ARADDR_F, AWADDR_F, WDATA_F;
    logic [3:0] ARLEN, AWLEN, WSTRB, ARLEN_F, AWLEN_F, WSTRB_F;
    logic [2:0] ARSIZE, AWSIZE, ARSIZE_F, AWSIZE_F;
    logic [1:0] ARBURST, AWBURST, RRESP, BRESP, ARBURST_F, AWBURST_F;
    logic ARVALID, ARREADY, AWVALID, AWREADY, WLAST, WVALID, WREADY, WLAST_F;
    logic RLAST, RVALID, RREADY, BVALID, BREADY;
    logic master_read_addr_fifo_empty, master_write_addr_fifo_empty;
    logic [0:0] read_addr_forward_dest_slave, write_addr_forward_dest_slave;
    logic [0:1] slave_read_addr_fifo_full, slave_write_addr_fifo_full, slave_write_data_fifo_full;
    logic [0:1] master_write_data_fifo_empty, master_read_data_fifo_full, master_write_resp_fifo_full;
    logic [0:1] RLAST_F, slave_read_data_fifo_empty, slave_write_resp_fifo_empty;
    logic [0:0] grant_ar [0:1];
    logic [0:0] grant_aw [0:1];
    logic [0:0] w_src [0:1];
    logic [0:0] r_dest [0:1];
    logic [0:0] b_dest [0:1];
    logic [3:0] RID_F [0:1];
    logic [31:0] RDATA_F [0:1];
    logic [1:0] RRESP_F [0:1];
    logic [3:0] BID_F [0:1];
    logic [1:0] BRESP_F [0:1];

    logic [31:0] sd [0:1][0:2];
    int scnt [0:1];
    int sidx [0:1];
    logic [3:0] rx_id [0:7];
    logic [31:0] rx_d [0:7];
    logic rx_l [0:7];
    int rx_n;
    logic onehot_bad;

    xbar_slave_port dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID_F(ARID_F), .ARADDR_F(ARADDR_F), .ARLEN_F(ARLEN_F), .ARSIZE_F(ARSIZE_F), .ARBURST_F(ARBURST_F),
        .AWID_F(AWID_F), .AWADDR_F(AWADDR_F), .AWLEN_F(AWLEN_F), .AWSIZE_F(AWSIZE_F), .AWBURST_F(AWBURST_F),
        .WDATA_F(WDATA_F), .WSTRB_F(WSTRB_F), .WLAST_F(WLAST_F),
        .master_read_addr_fifo_empty(master_read_addr_fifo_empty),
        .read_addr_forward_dest_slave(read_addr_forward_dest_slave),
        .slave_read_addr_fifo_full(slave_read_addr_fifo_full),
        .grant_read_addr_forward_master(grant_ar),
        .master_write_addr_fifo_empty(master_write_addr_fifo_empty),
        .write_addr_forward_dest_slave(write_addr_forward_dest_slave),
        .slave_write_addr_fifo_full(slave_write_addr_fifo_full),
        .grant_write_addr_forward_master(grant_aw),
        .master_write_data_fifo_empty(master_write_data_fifo_empty),
        .slave_write_data_fifo_full(slave_write_data_fifo_full),
        .write_data_forward_src_master(w_src),
        .RID_F(RID_F), .RDATA_F(RDATA_F), .RRESP_F(RRESP_F), .RLAST_F(RLAST_F),
        .slave_read_data_fifo_empty(slave_read_data_fifo_empty),
        .read_data_return_dest_master(r_dest),
        .master_read_data_fifo_full(master_read_data_fifo_full),
        .BID_F(BID_F), .BRESP_F(BRESP_F),
        .slave_write_resp_fifo_empty(slave_write_resp_fifo_empty),
        .write_resp_return_dest_master(b_dest),
        .master_write_resp_fifo_full(master_write_resp_fifo_full)
    );

    task automatic init_inputs();
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'd1; ARVALID = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'd1; AWVALID = 1'b0;
        WDATA = '0; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b0;
        RREADY = 1'b1; BREADY = 1'b1;
        slave_read_addr_fifo_full = '0; slave_write_addr_fifo_full = '0; slave_write_data_fifo_full = '0;
        slave_read_data_fifo_empty = '1; slave_write_resp_fifo_empty = '1; RLAST_F = '0;
        for (int s = 0; s < 2; s++) begin
            grant_ar[s] = 1'b1; grant_aw[s] = 1'b1; w_src[s] = 1'b1;
            r_dest[s] = 1'b1; b_dest[s] = 1'b1;
            RID_F[s] = '0; RDATA_F[s] = '0; RRESP_F[s] = '0; BID_F[s] = '0; BRESP_F[s] = '0;
        end
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK) ARESETn = 1'b1;
        repeat (5) @(negedge ACLK);
        #1;
        checks++; if ({ARREADY, AWREADY, WREADY} !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b expected 111", {ARREADY, AWREADY, WREADY}); end
        checks++; if ({RVALID, BVALID} !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", {RVALID, BVALID}); end
        checks++; if ({master_read_addr_fifo_empty, master_write_addr_fifo_empty} !== 2'b11) begin errors++; $display("FAIL reset_addr_empty: got %b expected 11", {master_read_addr_fifo_empty, master_write_addr_fifo_empty}); end
        checks++; if (master_write_data_fifo_empty !== 2'b11) begin errors++; $display("FAIL reset_w_empty: got %b expected 11", master_write_data_fifo_empty); end
        checks++; if (master_read_data_fifo_full !== 2'b11) begin errors++; $display("FAIL reset_r_full: got %b expected 11", master_read_data_fifo_full); end
        checks++; if (master_write_resp_fifo_full !== 2'b11) begin errors++; $display("FAIL reset_b_full: got %b expected 11", master_write_resp_fifo_full); end
        checks++; if ({read_addr_forward_dest_slave, write_addr_forward_dest_slave} !== 2'b00) begin errors++; $display("FAIL reset_dest: got %b expected 00", {read_addr_forward_dest_slave, write_addr_forward_dest_slave}); end
    endtask

    task automatic test_ar_decode();
        @(negedge ACLK);
        ARVALID = 1'b1; ARADDR = 32'h8000_0000; ARID = 4'h5; ARLEN = 4'd2;
        @(negedge ACLK);
        ARVALID = 1'b0;
        #1;
        checks++; if ({master_read_addr_fifo_empty, read_addr_forward_dest_slave} !== 2'b01) begin errors++; $display("FAIL ar_visible: got empty/dest %b expected 01", {master_read_addr_fifo_empty, read_addr_forward_dest_slave}); end
        checks++; if (ARADDR_F !== 32'h8000_0000 || ARID_F !== 4'h5 || ARLEN_F !== 4'd2) begin errors++; $display("FAIL ar_payload: got %h/%h/%h expected 80000000/5/2", ARADDR_F, ARID_F, ARLEN_F); end
        @(negedge ACLK);
        grant_ar[1] = 1'b0;
        @(negedge ACLK);
        grant_ar[1] = 1'b1;
        #1;
        checks++; if ({master_read_addr_fifo_empty, read_addr_forward_dest_slave} !== 2'b10) begin errors++; $display("FAIL ar_popped: got empty/dest %b expected 10", {master_read_addr_fifo_empty, read_addr_forward_dest_slave}); end
    endtask

    task automatic test_w_steering();
        logic [0:1] mask [0:4];
        logic [31:0] data [0:4];
        logic last [0:4];
        logic [0:1] exp_mask;
        int n;
        for (int s = 0; s < 2; s++) w_src[s] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            WVALID = 1'b1; WDATA = 32'hD0 + k; WLAST = (k == 3 || k == 4);
        end
        @(negedge ACLK);
        WVALID = 1'b0;
        #1;
        checks++; if (master_write_data_fifo_empty !== 2'b11) begin errors++; $display("FAIL w_early_held: got %b expected 11", master_write_data_fifo_empty); end
        @(negedge ACLK);
        AWVALID = 1'b1; AWADDR = 32'h0000_1000; AWLEN = 4'd3;
        @(negedge ACLK);
        AWADDR = 32'h8000_2000; AWLEN = 4'd0;
        @(negedge ACLK);
        AWVALID = 1'b0;
        #1;
        checks++; if (master_write_addr_fifo_empty !== 1'b0 || write_addr_forward_dest_slave !== 1'b0 || AWLEN_F !== 4'd3) begin errors++; $display("FAIL aw_head: got empty %b dest %b len %h expected 0 0 3", master_write_addr_fifo_empty, write_addr_forward_dest_slave, AWLEN_F); end
        for (int s = 0; s < 2; s++) grant_aw[s] = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 30 && n < 5; cyc++) begin
            @(negedge ACLK);
            #1;
            if (master_write_data_fifo_empty !== 2'b11) begin
                mask[n] = master_write_data_fifo_empty; data[n] = WDATA_F; last[n] = WLAST_F;
                n++;
            end
        end
        checks++; if (n != 5) begin errors++; $display("FAIL w_beat_count: got %0d expected 5", n); end
        for (int k = 0; k < n; k++) begin
            exp_mask = (k < 4) ? 2'b01 : 2'b10;
            checks++;
            if (mask[k] !== exp_mask || data[k] !== 32'hD0 + k || last[k] !== (k >= 3)) begin
                errors++;
                $display("FAIL w_beat%0d: got mask %b data %h last %b expected %b %h %b", k, mask[k], data[k], last[k], exp_mask, 32'hD0 + k, (k >= 3));
            end
        end
        checks++; if (master_write_addr_fifo_empty !== 1'b1) begin errors++; $display("FAIL aw_drained: got %b expected 1", master_write_addr_fifo_empty); end
        @(negedge ACLK);
        WVALID = 1'b1; WDATA = 32'hEE; WLAST = 1'b1;
        @(negedge ACLK);
        WVALID = 1'b0;
        repeat (3) @(negedge ACLK);
        #1;
        checks++; if (master_write_data_fifo_empty !== 2'b11) begin errors++; $display("FAIL dq_empty_after_wlast: got %b expected 11", master_write_data_fifo_empty); end
    endtask

    task automatic r_run(input int exp_n);
        rx_n = 0;
        onehot_bad = 1'b0;
        for (int cyc = 0; cyc < 60 && rx_n < exp_n; cyc++) begin
            @(negedge ACLK);
            for (int s = 0; s < 2; s++) begin
                if (sidx[s] < scnt[s]) begin
                    slave_read_data_fifo_empty[s] = 1'b0; r_dest[s] = 1'b0;
                    RDATA_F[s] = sd[s][sidx[s]]; RLAST_F[s] = (sidx[s] == scnt[s] - 1); RID_F[s] = 4'(s + 1);
                end else begin
                    slave_read_data_fifo_empty[s] = 1'b1;
                end
            end
            RREADY = !(cyc >= 2 && cyc < 7);
            #1;
            if (master_read_data_fifo_full == 2'b00) onehot_bad = 1'b1;
            for (int s = 0; s < 2; s++) if (!master_read_data_fifo_full[s]) sidx[s]++;
            if (RVALID && RREADY) begin
                rx_id[rx_n] = RID; rx_d[rx_n] = RDATA; rx_l[rx_n] = RLAST;
                rx_n++;
            end
        end
        @(negedge ACLK);
        slave_read_data_fifo_empty = '1; RREADY = 1'b1;
    endtask

    task automatic test_r_return();
        logic [31:0] ed;
        logic [3:0] eid;
        scnt[0] = 0; scnt[1] = 1; sidx[0] = 0; sidx[1] = 0;
        sd[1][0] = 32'h11;
        r_run(1);
        checks++; if (rx_n != 1 || rx_d[0] !== 32'h11 || rx_id[0] !== 4'd2 || rx_l[0] !== 1'b1) begin errors++; $display("FAIL r_single: got n %0d data %h id %h last %b expected 1 11 2 1", rx_n, rx_d[0], rx_id[0], rx_l[0]); end
        scnt[0] = 3; scnt[1] = 3; sidx[0] = 0; sidx[1] = 0;
        for (int k = 0; k < 3; k++) begin
            sd[0][k] = 32'hA0 + k; sd[1][k] = 32'hB0 + k;
        end
        r_run(6);
        checks++; if (rx_n != 6) begin errors++; $display("FAIL r_burst_count: got %0d expected 6", rx_n); end
        checks++; if (onehot_bad !== 1'b0) begin errors++; $display("FAIL r_single_pop: got %b expected 0", onehot_bad); end
        for (int k = 0; k < rx_n; k++) begin
            ed  = (k < 3) ? 32'hA0 + k : 32'hB0 + k - 3;
            eid = (k < 3) ? 4'd1 : 4'd2;
            checks++;
            if (rx_d[k] !== ed || rx_id[k] !== eid || rx_l[k] !== (k == 2 || k == 5)) begin
                errors++;
                $display("FAIL r_beat%0d: got data %h id %h last %b expected %h %h %b", k, rx_d[k], rx_id[k], rx_l[k], ed, eid, (k == 2 || k == 5));
            end
        end
    endtask

    task automatic b_run(input int exp_n);
        rx_n = 0;
        for (int cyc = 0; cyc < 40 && rx_n < exp_n; cyc++) begin
            @(negedge ACLK);
            for (int s = 0; s < 2; s++) begin
                if (sidx[s] < scnt[s]) begin
                    slave_write_resp_fifo_empty[s] = 1'b0; b_dest[s] = 1'b0;
                    BID_F[s] = 4'(s * 4 + sidx[s]); BRESP_F[s] = 2'(s + 1);
                end else begin
                    slave_write_resp_fifo_empty[s] = 1'b1;
                end
            end
            #1;
            for (int s = 0; s < 2; s++) if (!master_write_resp_fifo_full[s]) sidx[s]++;
            if (BVALID && BREADY) begin
                rx_id[rx_n] = BID; rx_d[rx_n] = 32'(BRESP);
                rx_n++;
            end
        end
        @(negedge ACLK);
        slave_write_resp_fifo_empty = '1;
    endtask

    task automatic test_b_return();
        logic [3:0] eid [0:3];
        logic [31:0] er [0:3];
        eid[0] = 4'd0; eid[1] = 4'd4; eid[2] = 4'd1; eid[3] = 4'd5;
        er[0] = 32'd1; er[1] = 32'd2; er[2] = 32'd1; er[3] = 32'd2;
        scnt[0] = 0; scnt[1] = 1; sidx[0] = 0; sidx[1] = 0;
        b_run(1);
        checks++; if (rx_n != 1 || rx_id[0] !== 4'd4) begin errors++; $display("FAIL b_single: got n %0d id %h expected 1 4", rx_n, rx_id[0]); end
        scnt[0] = 2; scnt[1] = 2; sidx[0] = 0; sidx[1] = 0;
        b_run(4);
        checks++; if (rx_n != 4) begin errors++; $display("FAIL b_count: got %0d expected 4", rx_n); end
        for (int k = 0; k < rx_n; k++) begin
            checks++;
            if (rx_id[k] !== eid[k] || rx_d[k] !== er[k]) begin
                errors++;
                $display("FAIL b_resp%0d: got id %h resp %0d expected %h %0d", k, rx_id[k], rx_d[k], eid[k], er[k]);
            end
        end
    endtask

    task automatic test_ar_full();
        logic ready_bad;
        ready_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge ACLK);
            ARVALID = 1'b1; ARADDR = 32'h100 + 32'(i * 16);
            #1;
            if (ARREADY !== 1'b1) ready_bad = 1'b1;
        end
        checks++; if (ready_bad !== 1'b0) begin errors++; $display("FAIL ar_fill_ready: got drop %b expected 0", ready_bad); end
        @(negedge ACLK);
        ARADDR = 32'h900;
        #1;
        checks++; if (ARREADY !== 1'b0 || ARADDR_F !== 32'h100) begin errors++; $display("FAIL ar_full: got ready %b head %h expected 0 100", ARREADY, ARADDR_F); end
        @(negedge ACLK);
        grant_ar[0] = 1'b0;
        @(negedge ACLK);
        grant_ar[0] = 1'b1;
        #1;
        checks++; if (ARREADY !== 1'b1 || ARADDR_F !== 32'h110) begin errors++; $display("FAIL ar_after_pop: got ready %b head %h expected 1 110", ARREADY, ARADDR_F); end
        @(negedge ACLK);
        ARVALID = 1'b0;
    endtask

    task automatic test_reset_mid_w();
        for (int s = 0; s < 2; s++) w_src[s] = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b1; AWADDR = 32'h0000_3000; AWLEN = 4'd3;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b1; WDATA = 32'hC0; WLAST = 1'b0;
        @(negedge ACLK);
        WDATA = 32'hC1;
        @(negedge ACLK);
        WVALID = 1'b0;
        ARESETn = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        for (int s = 0; s < 2; s++) w_src[s] = 1'b0;
        #1;
        checks++; if (WREADY !== 1'b1 || ARREADY !== 1'b1) begin errors++; $display("FAIL rst_ready: got w %b ar %b expected 1 1", WREADY, ARREADY); end
        checks++; if (master_write_data_fifo_empty !== 2'b11) begin errors++; $display("FAIL rst_w_empty: got %b expected 11", master_write_data_fifo_empty); end
        checks++; if ({master_read_addr_fifo_empty, master_write_addr_fifo_empty} !== 2'b11) begin errors++; $display("FAIL rst_addr_empty: got %b expected 11", {master_read_addr_fifo_empty, master_write_addr_fifo_empty}); end
        @(negedge ACLK);
        WVALID = 1'b1; WDATA = 32'hC2;
        @(negedge ACLK);
        WVALID = 1'b0;
        repeat (3) @(negedge ACLK);
        #1;
        checks++; if (master_write_data_fifo_empty !== 2'b11) begin errors++; $display("FAIL rst_no_w_pop: got %b expected 11", master_write_data_fifo_empty); end
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_ar_decode();
        test_w_steering();
        test_r_return();
        test_b_return();
        test_ar_full();
        test_reset_mid_w();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end
endmodule
